// File: rtl/mvau_stream_out_ctrl_pkg.sv
// Shared definitions for the MVAU output-stream path: default word geometry,
// the output word type and the derived-width helper used for counter/pointer sizing.
package mvau_stream_out_ctrl_pkg;

    localparam int unsigned PE_DEF    = 2;
    localparam int unsigned TDSTI_DEF = 16;
    localparam int unsigned NF_DEF    = 4;
    localparam int unsigned DEPTH_DEF = 8;

    // Output word of the default configuration: PE_DEF lanes of TDSTI_DEF bits.
    typedef logic [TDSTI_DEF-1:0] acc_lane_t;
    typedef acc_lane_t [PE_DEF-1:0] acc_word_t;

    // Index width that never collapses to zero bits, so a counter over a
    // single-value range still has a legal declaration.
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mvau_sfifo.sv
// Generic synchronous FIFO with one-extra-bit pointers; the pointer MSB
// separates full from empty. Storage is not reset; read data is combinational.
module mvau_sfifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       wr_en_i,
    input  logic [WIDTH-1:0]           wr_data_i,
    input  logic                       rd_en_i,
    output logic [WIDTH-1:0]           rd_data_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o
);
    localparam int unsigned DEPTH_T = $clog2(DEPTH);
    localparam logic [DEPTH_T:0] DEPTH_CNT = (DEPTH_T+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [DEPTH_T:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_T:0] rd_ptr_q, rd_ptr_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q + {{DEPTH_T{1'b0}}, wr_en_i};
        rd_ptr_d = rd_ptr_q + {{DEPTH_T{1'b0}}, rd_en_i};
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_ptr_q[DEPTH_T-1:0]] <= wr_data_i;
        end
    end

    always_comb begin
        count_o   = wr_ptr_q - rd_ptr_q;
        full_o    = (count_o == DEPTH_CNT);
        empty_o   = (count_o == '0);
        rd_data_o = mem_q[rd_ptr_q[DEPTH_T-1:0]];
    end

endmodule

// File: rtl/mvau_stream_out_ctrl.sv
// Output-side control of the MVAU stream: buffers completed accumulator chunks,
// tags the last chunk of each vector and stalls upstream ahead of overflow.
module mvau_stream_out_ctrl
    import mvau_stream_out_ctrl_pkg::*;
#(
    parameter int unsigned PE       = PE_DEF,
    parameter int unsigned TDstI    = TDSTI_DEF,
    parameter int unsigned NF       = NF_DEF,
    parameter int unsigned DEPTH    = DEPTH_DEF,
    parameter int unsigned PIPE_LAT = 2,
    parameter int unsigned DEPTH_T  = $clog2(DEPTH),
    parameter int unsigned NF_T     = clog2_min1(NF)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  acc_v,
    input  logic [PE*TDstI-1:0]   acc_data,
    input  logic                  out_rdy,
    output logic                  out_v,
    output logic [PE*TDstI-1:0]   out_data,
    output logic                  out_last,
    output logic                  stall,
    output logic                  ovf_err
);
    localparam int unsigned W = PE * TDstI;
    localparam logic [DEPTH_T:0] STALL_TH = (DEPTH_T+1)'(DEPTH - PIPE_LAT);

    logic             full;
    logic             empty;
    logic [DEPTH_T:0] count;
    logic             rd_fire;
    logic             wr_fire;
    logic             drop;
    logic             ovf_q, ovf_d;

    always_comb begin
        out_v   = ~empty;
        rd_fire = out_v & out_rdy;
        // A full FIFO still accepts a word when the same edge frees a slot.
        wr_fire = acc_v & (~full | rd_fire);
        drop    = acc_v & full & ~rd_fire;
        ovf_d   = ovf_q | drop;
        stall   = (count >= STALL_TH);
        ovf_err = ovf_q;
    end

    mvau_sfifo #(
        .WIDTH (W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i     (clk),
        .rst_i     (rst),
        .wr_en_i   (wr_fire),
        .wr_data_i (acc_data),
        .rd_en_i   (rd_fire),
        .rd_data_o (out_data),
        .full_o    (full),
        .empty_o   (empty),
        .count_o   (count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    generate
        if (NF > 1) begin : g_nf_cnt
            localparam logic [NF_T-1:0] NF_LAST = NF_T'(NF - 1);
            logic [NF_T-1:0] nf_cnt_q, nf_cnt_d;

            always_comb begin
                nf_cnt_d = nf_cnt_q;
                if (rd_fire) begin
                    nf_cnt_d = (nf_cnt_q == NF_LAST) ? '0 : nf_cnt_q + 1'b1;
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    nf_cnt_q <= '0;
                end else begin
                    nf_cnt_q <= nf_cnt_d;
                end
            end

            assign out_last = out_v & (nf_cnt_q == NF_LAST);
        end else begin : g_nf_single
            assign out_last = out_v;
        end
    endgenerate

endmodule

// File: tb/tb_mvau_stream_out_ctrl.sv
// Directed bench for mvau_stream_out_ctrl: vector table plus hand-written
// overflow, full-with-read and NF=1 reset sequences.
module tb_mvau_stream_out_ctrl;

    logic        clk = 1'b0;
    logic        rst, acc_v, out_rdy;
    logic [31:0] acc_data;
    logic        out_v, out_last, stall, ovf_err;
    logic [31:0] out_data;

    logic        rst1, acc_v1, out_rdy1;
    logic [31:0] acc_data1;
    logic        out_v1, out_last1, stall1, ovf_err1;
    logic [31:0] out_data1;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mvau_stream_out_ctrl #(
        .PE(2), .TDstI(16), .NF(4), .DEPTH(8), .PIPE_LAT(2)
    ) dut (
        .clk(clk), .rst(rst), .acc_v(acc_v), .acc_data(acc_data), .out_rdy(out_rdy),
        .out_v(out_v), .out_data(out_data), .out_last(out_last), .stall(stall), .ovf_err(ovf_err)
    );

    mvau_stream_out_ctrl #(
        .PE(2), .TDstI(16), .NF(1), .DEPTH(8), .PIPE_LAT(2)
    ) dut1 (
        .clk(clk), .rst(rst1), .acc_v(acc_v1), .acc_data(acc_data1), .out_rdy(out_rdy1),
        .out_v(out_v1), .out_data(out_data1), .out_last(out_last1), .stall(stall1), .ovf_err(ovf_err1)
    );

    typedef struct {
        logic        rst;
        logic        acc_v;
        logic [31:0] data;
        logic        rdy;
        logic        e_v;
        logic [31:0] e_data;
        logic        e_last;
        logic        e_stall;
        logic        e_ovf;
        string       name;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic r, input logic av, input logic [31:0] d, input logic rd,
                                input logic ev, input logic [31:0] ed, input logic el,
                                input logic es, input logic eo, input string nm);
        vec_t v;
        v.rst = r; v.acc_v = av; v.data = d; v.rdy = rd;
        v.e_v = ev; v.e_data = ed; v.e_last = el; v.e_stall = es; v.e_ovf = eo; v.name = nm;
        vecs.push_back(v);
    endfunction

    function automatic logic [31:0] sword(input int k);
        return (32'(k) << 16) | 32'(k - 1);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_main(input string nm, input logic ev, input logic [31:0] ed,
                            input logic el, input logic es, input logic eo);
        chk({nm, ".out_v"}, 32'(out_v), 32'(ev));
        if (ev) chk({nm, ".out_data"}, out_data, ed);
        chk({nm, ".out_last"}, 32'(out_last), 32'(el));
        chk({nm, ".stall"}, 32'(stall), 32'(es));
        chk({nm, ".ovf_err"}, 32'(ovf_err), 32'(eo));
    endtask

    task automatic reset_main();
        rst = 1'b1; acc_v = 1'b0; acc_data = '0; out_rdy = 1'b0;
        step();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; acc_v = 1'b0; acc_data = '0; out_rdy = 1'b0;
        rst1 = 1'b1; acc_v1 = 1'b0; acc_data1 = '0; out_rdy1 = 1'b0;

        // Reset then idle.
        add(1, 0, 0, 0, 0, 0, 0, 0, 0, "reset");
        for (int i = 0; i < 10; i++) add(0, 0, 0, 0, 0, 0, 0, 0, 0, $sformatf("idle%0d", i));

        // Streaming with out_rdy held high.
        add(1, 0, 0, 0, 0, 0, 0, 0, 0, "stream_rst");
        for (int k = 1; k <= 8; k++)
            add(0, 1, sword(k), 1, 1, sword(k), (k % 4) == 0, 0, 0, $sformatf("stream%0d", k));
        add(0, 0, 0, 1, 0, 0, 0, 0, 0, "stream_end");

        // Backpressure: six writes reach the stall threshold, then drain.
        add(1, 0, 0, 0, 0, 0, 0, 0, 0, "bp_rst");
        for (int i = 1; i <= 6; i++)
            add(0, 1, 32'hB000_0000 + 32'(i), 0, 1, 32'hB000_0001, 0, i == 6, 0, $sformatf("bp_fill%0d", i));
        for (int j = 1; j <= 6; j++)
            add(0, 0, 0, 1, j < 6, 32'hB000_0000 + 32'(j + 1), (j < 6) && ((j % 4) == 3), 0, 0,
                $sformatf("bp_drain%0d", j));

        // Mid-stream reset realigns chunk position to 0.
        add(1, 0, 0, 0, 0, 0, 0, 0, 0, "mr_rst0");
        for (int i = 1; i <= 5; i++)
            add(0, 1, 32'hC000_0000 + 32'(i), 0, 1, 32'hC000_0001, 0, 0, 0, $sformatf("mr_fill%0d", i));
        for (int j = 1; j <= 2; j++)
            add(0, 0, 0, 1, 1, 32'hC000_0000 + 32'(j + 1), 0, 0, 0, $sformatf("mr_read%0d", j));
        add(1, 0, 0, 0, 0, 0, 0, 0, 0, "mr_rst1");
        for (int k = 1; k <= 4; k++)
            add(0, 1, 32'hD000_0000 + 32'(k), 1, 1, 32'hD000_0000 + 32'(k), k == 4, 0, 0,
                $sformatf("mr_stream%0d", k));
        add(0, 0, 0, 1, 0, 0, 0, 0, 0, "mr_end");

        foreach (vecs[i]) begin
            rst = vecs[i].rst; acc_v = vecs[i].acc_v; acc_data = vecs[i].data; out_rdy = vecs[i].rdy;
            step();
            chk_main(vecs[i].name, vecs[i].e_v, vecs[i].e_data, vecs[i].e_last, vecs[i].e_stall, vecs[i].e_ovf);
        end

        // Overflow: nine writes into a stalled FIFO, the ninth is lost.
        reset_main();
        for (int i = 1; i <= 9; i++) begin
            acc_v = 1'b1; acc_data = 32'hE000_0000 + 32'(i); out_rdy = 1'b0;
            step();
            chk_main($sformatf("ovf_fill%0d", i), 1, 32'hE000_0001, 0, i >= 6, i == 9);
        end
        acc_v = 1'b0; out_rdy = 1'b1;
        for (int j = 1; j <= 8; j++) begin
            step();
            chk_main($sformatf("ovf_drain%0d", j), j < 8, 32'hE000_0000 + 32'(j + 1),
                     (j < 8) && ((j % 4) == 3), (8 - j) >= 6, 1);
        end
        out_rdy = 1'b0;

        // Full plus simultaneous read: new word accepted, count stays at depth.
        reset_main();
        for (int i = 1; i <= 8; i++) begin
            acc_v = 1'b1; acc_data = 32'hF000_0000 + 32'(i);
            step();
        end
        chk_main("full_pre", 1, 32'hF000_0001, 0, 1, 0);
        acc_v = 1'b1; acc_data = 32'hF000_0009; out_rdy = 1'b1;
        step();
        chk_main("full_rw", 1, 32'hF000_0002, 0, 1, 0);
        acc_v = 1'b0;
        for (int j = 1; j <= 8; j++) begin
            step();
            chk_main($sformatf("full_drain%0d", j), j < 8, 32'hF000_0000 + 32'(j + 2),
                     (j < 8) && (((j + 1) % 4) == 3), (8 - j) >= 6, 0);
        end
        out_rdy = 1'b0;

        // NF=1 build: out_last follows out_v; reset with three words buffered.
        step();
        rst1 = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            acc_v1 = 1'b1; acc_data1 = 32'hA100_0000 + 32'(k); out_rdy1 = 1'b1;
            step();
            chk($sformatf("nf1_stream%0d.out_v", k), 32'(out_v1), 1);
            chk($sformatf("nf1_stream%0d.out_last", k), 32'(out_last1), 1);
            chk($sformatf("nf1_stream%0d.out_data", k), out_data1, 32'hA100_0000 + 32'(k));
        end
        acc_v1 = 1'b0;
        step();
        chk("nf1_empty.out_v", 32'(out_v1), 0);
        chk("nf1_empty.out_last", 32'(out_last1), 0);
        out_rdy1 = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            acc_v1 = 1'b1; acc_data1 = 32'hA200_0000 + 32'(k);
            step();
            chk($sformatf("nf1_hold%0d.out_last", k), 32'(out_last1), 1);
            chk($sformatf("nf1_hold%0d.out_data", k), out_data1, 32'hA200_0001);
        end
        acc_v1 = 1'b0; rst1 = 1'b1;
        step();
        chk("nf1_rst.out_v", 32'(out_v1), 0);
        chk("nf1_rst.out_last", 32'(out_last1), 0);
        chk("nf1_rst.stall", 32'(stall1), 0);
        rst1 = 1'b0; acc_v1 = 1'b1; acc_data1 = 32'hA300_0001; out_rdy1 = 1'b1;
        step();
        chk("nf1_post.out_v", 32'(out_v1), 1);
        chk("nf1_post.out_last", 32'(out_last1), 1);
        chk("nf1_post.out_data", out_data1, 32'hA300_0001);
        acc_v1 = 1'b0;
        step();
        chk("nf1_post_end.out_v", 32'(out_v1), 0);
        chk("nf1_post_end.ovf_err", 32'(ovf_err1), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
